// File: rtl/intc_cp0_sched.sv
// rtl/intc_cp0_sched.sv - interrupt synchroniser, latch/mask and CP0 HWINT request sequencer
// Optional build macro: INTC_PRIORITY_EN (hw_int carries only the lowest-index request)
module intc_cp0_sched #(
    parameter int N_SRC       = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] irq_in,
    input  logic [1:0]       reg_addr,
    input  logic             reg_we,
    input  logic [31:0]      reg_wd,
    output logic [31:0]      reg_rd,
    input  logic             cp0_take,
    input  logic             cp0_eret,
    output logic [5:0]       hw_int
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    localparam logic [1:0] A_PEND = 2'd0;
    localparam logic [1:0] A_MASK = 2'd1;
    localparam logic [1:0] A_MODE = 2'd2;
    localparam logic [1:0] A_STAT = 2'd3;

    logic [SYNC_STAGES-1:0][N_SRC-1:0] sync_q;
    logic [N_SRC-1:0] s;
    logic [N_SRC-1:0] prev;
    logic [N_SRC-1:0] pend;
    logic [N_SRC-1:0] pend_d;
    logic [N_SRC-1:0] mask;
    logic [N_SRC-1:0] mode;
    logic [N_SRC-1:0] req;
    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] w1c;
    logic [5:0]       req6;
    logic [5:0]       hw_d;
    logic [2:0]       low_idx;
    logic [2:0]       svc_id;
    logic             unused_wd;
    state_t           state;
    state_t           next_state;

    assign unused_wd = ^reg_wd[31:N_SRC];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
            prev   <= '0;
        end else begin
            sync_q[0] <= irq_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev <= s;
        end
    end

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~prev;
    assign w1c  = (reg_we && reg_addr == A_PEND) ? reg_wd[N_SRC-1:0] : '0;

    // Edge sources hold until W1C (a new edge beats a same-cycle clear); level sources track s.
    assign pend_d = (mode & (rise | (pend & ~w1c))) | (~mode & s);
    assign req    = pend & mask;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend <= '0;
            mask <= '0;
            mode <= '0;
        end else begin
            pend <= pend_d;
            if (reg_we) begin
                case (reg_addr)
                    A_MASK:  mask <= reg_wd[N_SRC-1:0];
                    A_MODE:  mode <= reg_wd[N_SRC-1:0];
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        req6              = '0;
        req6[N_SRC-1:0]   = req;
        low_idx           = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                low_idx = 3'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (req != '0) next_state = REQ;
            REQ: begin
                if (cp0_take) begin
                    next_state = SERVICE;
                end else if (req == '0) begin
                    next_state = IDLE;
                end
            end
            SERVICE: if (cp0_eret) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Request is only presented while headed into REQ, giving CP0 a clean gap across ERET.
    always_comb begin
        hw_d = '0;
        if (next_state == REQ) begin
`ifdef INTC_PRIORITY_EN
            hw_d = req6 & (~req6 + 6'd1);
`else
            hw_d = req6;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hw_int <= '0;
            svc_id <= '0;
        end else begin
            hw_int <= hw_d;
            if (state == REQ && cp0_take) begin
                svc_id <= low_idx;
            end
        end
    end

    always_comb begin
        reg_rd = '0;
        case (reg_addr)
            A_PEND:  reg_rd[N_SRC-1:0] = pend;
            A_MASK:  reg_rd[N_SRC-1:0] = mask;
            A_MODE:  reg_rd[N_SRC-1:0] = mode;
            A_STAT:  reg_rd = {25'd0, svc_id, 2'b00, state};
            default: reg_rd = '0;
        endcase
    end

endmodule

// File: tb/tb_intc_cp0_sched.sv
// tb/tb_intc_cp0_sched.sv - self-checking bench for intc_cp0_sched
module tb_intc_cp0_sched;
    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  irq_in;
    logic [1:0]  reg_addr;
    logic        reg_we;
    logic [31:0] reg_wd;
    logic [31:0] reg_rd;
    logic        cp0_take;
    logic        cp0_eret;
    logic [5:0]  hw_int;

    int errors = 0;
    int checks = 0;
    logic [5:0] exp_q[$];

    always #5 clk = ~clk;

    intc_cp0_sched #(.N_SRC(6), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .irq_in   (irq_in),
        .reg_addr (reg_addr),
        .reg_we   (reg_we),
        .reg_wd   (reg_wd),
        .reg_rd   (reg_rd),
        .cp0_take (cp0_take),
        .cp0_eret (cp0_eret),
        .hw_int   (hw_int)
    );

    function automatic logic [5:0] exp_hw(input logic [5:0] r);
`ifdef INTC_PRIORITY_EN
        for (int i = 0; i < 6; i++) begin
            if (r[i]) return 6'(1 << i);
        end
        return 6'h00;
`else
        return r;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
        reg_addr = a;
        reg_wd   = d;
        reg_we   = 1'b1;
        tick();
        reg_we   = 1'b0;
        reg_wd   = '0;
    endtask

    task automatic reg_read(input logic [1:0] a, output logic [31:0] d);
        reg_addr = a;
        #1;
        d = reg_rd;
    endtask

    task automatic wait_hw(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            tick();
            if (hw_int !== 6'h00) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic pop_hw(input string name, input bit ok);
        logic [5:0] e;
        e = exp_q.pop_front();
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: timeout, hw_int=%h want %h", name, hw_int, e);
        end else if (hw_int !== e) begin
            errors++;
            $display("FAIL %s: hw_int=%h want %h", name, hw_int, e);
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        bit ok;
        checks++;
        if (hw_int !== 6'h00) begin errors++; $display("FAIL por_hw: got %h want 00", hw_int); end
        reg_read(2'd3, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL por_stat: got %h want 0", d); end
        rst = 1'b1;
        tick();
        reg_write(2'd2, 32'h3F);
        reg_write(2'd1, 32'h3F);
        irq_in = 6'h3F;
        exp_q.push_back(exp_hw(6'h3F));
        wait_hw(8, ok);
        pop_hw("rst_req_hw", ok);
        cp0_take = 1'b1;
        tick();
        cp0_take = 1'b0;
        reg_read(2'd3, d);
        checks++;
        if (d !== 32'h02) begin errors++; $display("FAIL rst_svc_stat: got %h want 02", d); end
        #1 rst = 1'b0;
        #1;
        checks++;
        if (hw_int !== 6'h00) begin errors++; $display("FAIL rst_async_hw: got %h want 00", hw_int); end
        for (int a = 0; a < 4; a++) begin
            reg_read(2'(a), d);
            checks++;
            if (d !== 32'h0) begin errors++; $display("FAIL rst_async_reg%0d: got %h want 0", a, d); end
        end
        irq_in = 6'h00;
        tick();
        tick();
        rst = 1'b1;
        repeat (4) tick();
        checks++;
        if (hw_int !== 6'h00) begin errors++; $display("FAIL rst_after_hw: got %h want 00", hw_int); end
        for (int a = 0; a < 4; a++) begin
            reg_read(2'(a), d);
            checks++;
            if (d !== 32'h0) begin errors++; $display("FAIL rst_after_reg%0d: got %h want 0", a, d); end
        end
    endtask

    task automatic test_edge_latency();
        logic [31:0] d;
        tick();
        reg_write(2'd2, 32'h01);
        reg_write(2'd1, 32'h01);
        tick();
        irq_in = 6'h01;
        exp_q.push_back(6'h01);
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k < 4) begin
                checks++;
                if (hw_int !== 6'h00) begin errors++; $display("FAIL lat_early%0d: got %h want 00", k, hw_int); end
            end else begin
                pop_hw("lat_edge4", 1'b1);
            end
        end
        reg_read(2'd3, d);
        checks++;
        if (d !== 32'h01) begin errors++; $display("FAIL lat_stat: got %h want 01", d); end
        reg_write(2'd0, 32'h01);
        repeat (3) tick();
        reg_read(2'd0, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL lat_w1c_pend: got %h want 0", d); end
        repeat (4) tick();
        checks++;
        if (hw_int !== 6'h00) begin errors++; $display("FAIL lat_no_retrig: got %h want 00", hw_int); end
        reg_read(2'd3, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL lat_idle_stat: got %h want 0", d); end
        irq_in = 6'h00;
        repeat (3) tick();
    endtask

    task automatic test_service();
        logic [31:0] d;
        bit ok;
        reg_write(2'd2, 32'h3F);
        reg_write(2'd1, 32'h3F);
        irq_in = 6'h05;
        exp_q.push_back(exp_hw(6'h05));
        wait_hw(8, ok);
        pop_hw("svc_req_hw", ok);
        cp0_take = 1'b1;
        tick();
        cp0_take = 1'b0;
        checks++;
        if (hw_int !== 6'h00) begin errors++; $display("FAIL svc_hw0: got %h want 00", hw_int); end
        reg_read(2'd3, d);
        checks++;
        if (d !== 32'h02) begin errors++; $display("FAIL svc_stat: got %h want 02", d); end
        cp0_take = 1'b1;
        tick();
        cp0_take = 1'b0;
        reg_read(2'd3, d);
        checks++;
        if (d !== 32'h02 || hw_int !== 6'h00) begin
            errors++; $display("FAIL svc_take_ignored: stat %h hw %h want 02 00", d, hw_int);
        end
        exp_q.push_back(exp_hw(6'h05));
        cp0_eret = 1'b1;
        tick();
        cp0_eret = 1'b0;
        reg_read(2'd3, d);
        checks++;
        if (d !== 32'h0 || hw_int !== 6'h00) begin
            errors++; $display("FAIL svc_eret: stat %h hw %h want 0 00", d, hw_int);
        end
        tick();
        pop_hw("svc_reassert", 1'b1);
        cp0_eret = 1'b1;
        tick();
        cp0_eret = 1'b0;
        reg_read(2'd3, d);
        checks++;
        if (d !== 32'h01) begin errors++; $display("FAIL svc_eret_in_req: got %h want 01", d); end
        reg_write(2'd0, 32'h05);
        repeat (2) tick();
        checks++;
        if (hw_int !== 6'h00) begin errors++; $display("FAIL svc_clear_hw: got %h want 00", hw_int); end
        irq_in = 6'h00;
        repeat (3) tick();
    endtask

    task automatic test_w1c_race();
        logic [31:0] d;
        bit ok;
        irq_in = 6'h04;
        tick();
        tick();
        reg_addr = 2'd0;
        reg_wd   = 32'h04;
        reg_we   = 1'b1;
        #1;
        d = reg_rd;
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL race_pre_edge: got %h want 0", d); end
        tick();
        reg_we = 1'b0;
        reg_wd = '0;
        reg_read(2'd0, d);
        checks++;
        if (d !== 32'h04) begin errors++; $display("FAIL race_set_wins: got %h want 04", d); end
        exp_q.push_back(6'h04);
        wait_hw(4, ok);
        pop_hw("race_hw", ok);
        reg_write(2'd0, 32'h04);
        reg_read(2'd0, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL race_w1c: got %h want 0", d); end
        tick();
        reg_read(2'd3, d);
        checks++;
        if (hw_int !== 6'h00 || d !== 32'h0) begin
            errors++; $display("FAIL race_idle: hw %h stat %h want 00 0", hw_int, d);
        end
        irq_in = 6'h00;
        repeat (3) tick();
    endtask

    task automatic test_level();
        logic [31:0] d;
        bit lvl_q[$];
        bit v, e;
        reg_write(2'd2, 32'h00);
        reg_write(2'd1, 32'h20);
        repeat (3) tick();
        lvl_q.push_back(1'b0);
        lvl_q.push_back(1'b0);
        for (int k = 1; k <= 16; k++) begin
            v         = (k <= 10);
            irq_in[5] = v;
            reg_addr  = 2'd0;
            reg_wd    = 32'h20;
            reg_we    = (k == 6);
            lvl_q.push_back(v);
            tick();
            reg_we = 1'b0;
            e = lvl_q.pop_front();
            reg_read(2'd0, d);
            checks++;
            if (d !== {26'd0, e, 5'd0}) begin
                errors++; $display("FAIL level_pend%0d: got %h want %h", k, d, {26'd0, e, 5'd0});
            end
            if (k == 8) begin
                checks++;
                if (hw_int !== 6'h20) begin errors++; $display("FAIL level_hw: got %h want 20", hw_int); end
            end
        end
        checks++;
        if (hw_int !== 6'h00) begin errors++; $display("FAIL level_hw_low: got %h want 00", hw_int); end
    endtask

    task automatic test_priority();
        logic [31:0] d;
        bit ok;
        reg_write(2'd2, 32'h3F);
        reg_write(2'd1, 32'h3F);
        irq_in = 6'h2C;
        exp_q.push_back(exp_hw(6'h2C));
        wait_hw(8, ok);
        pop_hw("prio_hw", ok);
        cp0_take = 1'b1;
        tick();
        cp0_take = 1'b0;
        reg_read(2'd3, d);
        checks++;
        if (d !== 32'h22) begin errors++; $display("FAIL prio_svc_id: got %h want 22", d); end
        cp0_eret = 1'b1;
        tick();
        cp0_eret = 1'b0;
        reg_write(2'd0, 32'h2C);
        repeat (2) tick();
        reg_read(2'd3, d);
        checks++;
        if (hw_int !== 6'h00 || d !== 32'h20) begin
            errors++; $display("FAIL prio_done: hw %h stat %h want 00 20", hw_int, d);
        end
        irq_in = 6'h00;
        repeat (3) tick();
    endtask

    initial begin
        rst      = 1'b0;
        irq_in   = '0;
        reg_addr = '0;
        reg_we   = 1'b0;
        reg_wd   = '0;
        cp0_take = 1'b0;
        cp0_eret = 1'b0;
        tick();
        tick();
        test_reset();
        test_edge_latency();
        test_service();
        test_w1c_race();
        test_level();
        test_priority();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule
